// File: rtl/qbus_if.sv
// QBUS slave-side signal bundle between the synchronized bus interface and
// the register sequencer.
interface qbus_if;
    // SYNC frames one bus cycle and carries a valid address. DIN/DOUT request
    // a data transfer and RPLY acknowledges it. The master holds DIN/DOUT
    // until it sees RPLY, and the slave holds RPLY until DIN/DOUT drop.
    logic        bus_sync;
    logic        bus_bs7;
    logic [12:0] bus_addr;
    logic        bus_din;
    logic        bus_dout;
    logic        bus_wtbt;
    logic [15:0] bus_wdata;
    logic        bus_rply;
    logic [15:0] bus_rdata;
    logic        bus_rdata_oe;

    modport master (
        output bus_sync, bus_bs7, bus_addr, bus_din, bus_dout, bus_wtbt, bus_wdata,
        input  bus_rply, bus_rdata, bus_rdata_oe
    );

    modport slave (
        input  bus_sync, bus_bs7, bus_addr, bus_din, bus_dout, bus_wtbt, bus_wdata,
        output bus_rply, bus_rdata, bus_rdata_oe
    );
endinterface

// File: rtl/qbus_reg_seq.sv
// Slave-cycle sequencer for the I/O register mux: latches the I/O-page
// address, qualifies the mux match, and issues single-cycle register strobes.
module qbus_reg_seq #(
    parameter int unsigned MATCH_DLY  = 1,
    parameter int unsigned DATA_SETUP = 2
) (
    input  logic        clk,
    input  logic        reset_n,
    qbus_if.slave       bus,
    output logic [12:0] reg_addr,
    input  logic        reg_addr_match,
    input  logic [15:0] reg_rdata,
    output logic        reg_read,
    output logic        reg_write,
    output logic [15:0] reg_wdata,
    output logic [1:0]  reg_byte_en,
    output logic [3:0]  dbg_state
);

    typedef enum logic [3:0] {
        S_IDLE       = 4'd0,
        S_DECODE     = 4'd1,
        S_SELECTED   = 4'd2,
        S_READ       = 4'd3,
        S_READ_RPLY  = 4'd4,
        S_WSETUP     = 4'd5,
        S_WRITE      = 4'd6,
        S_WRITE_RPLY = 4'd7,
        S_WAIT_SYNC  = 4'd8
    } state_e;

    localparam logic [3:0] MATCH_CNT = 4'(MATCH_DLY);
    localparam logic [3:0] SETUP_CNT = 4'(DATA_SETUP);

    state_e      state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    logic [12:0] addr_q, addr_d;
    logic [15:0] rdata_q, rdata_d;
    logic [15:0] wdata_q, wdata_d;
    logic [1:0]  be_q, be_d;
    logic        rply_q, rply_d;
    logic        oe_q, oe_d;
    logic        read_q, read_d;
    logic        write_q, write_d;
    logic [1:0]  be_calc;

    // Byte writes pick the lane from the latched address LSB.
    assign be_calc = !bus.bus_wtbt ? 2'b11 : (addr_q[0] ? 2'b10 : 2'b01);

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        addr_d  = addr_q;
        rdata_d = rdata_q;
        wdata_d = wdata_q;
        be_d    = be_q;
        rply_d  = rply_q;
        oe_d    = oe_q;
        read_d  = 1'b0;
        write_d = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (bus.bus_sync) begin
                    if (bus.bus_bs7) begin
                        addr_d  = bus.bus_addr;
                        cnt_d   = MATCH_CNT;
                        state_d = S_DECODE;
                    end else begin
                        state_d = S_WAIT_SYNC;
                    end
                end
            end
            S_DECODE: begin
                if (cnt_q <= 4'd1) begin
                    state_d = reg_addr_match ? S_SELECTED : S_WAIT_SYNC;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            S_SELECTED: begin
                if (bus.bus_din) begin
                    read_d  = 1'b1;
                    state_d = S_READ;
                end else if (bus.bus_dout) begin
                    if (DATA_SETUP == 0) begin
                        write_d = 1'b1;
                        wdata_d = bus.bus_wdata;
                        be_d    = be_calc;
                        state_d = S_WRITE;
                    end else begin
                        cnt_d   = SETUP_CNT;
                        state_d = S_WSETUP;
                    end
                end
            end
            S_READ: begin
                rdata_d = reg_rdata;
                rply_d  = 1'b1;
                oe_d    = 1'b1;
                state_d = S_READ_RPLY;
            end
            S_READ_RPLY: begin
                if (!bus.bus_din) begin
                    rply_d  = 1'b0;
                    oe_d    = 1'b0;
                    state_d = S_SELECTED;
                end
            end
            S_WSETUP: begin
                if (cnt_q <= 4'd1) begin
                    write_d = 1'b1;
                    wdata_d = bus.bus_wdata;
                    be_d    = be_calc;
                    state_d = S_WRITE;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            S_WRITE: begin
                rply_d  = 1'b1;
                state_d = S_WRITE_RPLY;
            end
            S_WRITE_RPLY: begin
                if (!bus.bus_dout) begin
                    rply_d  = 1'b0;
                    state_d = S_SELECTED;
                end
            end
            S_WAIT_SYNC: begin
                state_d = S_WAIT_SYNC;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        // Losing SYNC ends the bus cycle from any state; no new strobe starts.
        if (state_q != S_IDLE && !bus.bus_sync) begin
            state_d = S_IDLE;
            rply_d  = 1'b0;
            oe_d    = 1'b0;
            read_d  = 1'b0;
            write_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= S_IDLE;
            cnt_q   <= 4'd0;
            addr_q  <= 13'd0;
            rdata_q <= 16'd0;
            wdata_q <= 16'd0;
            be_q    <= 2'b00;
            rply_q  <= 1'b0;
            oe_q    <= 1'b0;
            read_q  <= 1'b0;
            write_q <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            addr_q  <= addr_d;
            rdata_q <= rdata_d;
            wdata_q <= wdata_d;
            be_q    <= be_d;
            rply_q  <= rply_d;
            oe_q    <= oe_d;
            read_q  <= read_d;
            write_q <= write_d;
        end
    end

    assign bus.bus_rply     = rply_q;
    assign bus.bus_rdata    = rdata_q;
    assign bus.bus_rdata_oe = oe_q;
    assign reg_addr         = addr_q;
    assign reg_read         = read_q;
    assign reg_write        = write_q;
    assign reg_wdata        = wdata_q;
    assign reg_byte_en      = be_q;
    assign dbg_state        = state_q;

endmodule

// File: tb/tb_qbus_reg_seq.sv
// Directed bench for qbus_reg_seq: register-strobe scoreboard plus checks on
// RPLY, read data, latency and state around each bus cycle.
module tb_qbus_reg_seq;

    localparam int unsigned MATCH_DLY  = 1;
    localparam int unsigned DATA_SETUP = 2;

    localparam logic [3:0] ST_IDLE      = 4'd0;
    localparam logic [3:0] ST_SELECTED  = 4'd2;
    localparam logic [3:0] ST_WSETUP    = 4'd5;
    localparam logic [3:0] ST_WAIT_SYNC = 4'd8;

    localparam int W = 33;

    logic        clk;
    logic        reset_n;
    logic [12:0] reg_addr;
    logic        reg_addr_match;
    logic [15:0] reg_rdata;
    logic        reg_read;
    logic        reg_write;
    logic [15:0] reg_wdata;
    logic [1:0]  reg_byte_en;
    logic [3:0]  dbg_state;

    logic        match_en;
    logic [15:0] rdata_val;

    qbus_if bus ();

    qbus_reg_seq #(.MATCH_DLY(MATCH_DLY), .DATA_SETUP(DATA_SETUP)) dut (
        .clk            (clk),
        .reset_n        (reset_n),
        .bus            (bus),
        .reg_addr       (reg_addr),
        .reg_addr_match (reg_addr_match),
        .reg_rdata      (reg_rdata),
        .reg_read       (reg_read),
        .reg_write      (reg_write),
        .reg_wdata      (reg_wdata),
        .reg_byte_en    (reg_byte_en),
        .dbg_state      (dbg_state)
    );

    // Register mux model: registers live at 0x1F00..0x1F3F.
    assign reg_addr_match = match_en && (reg_addr[12:6] == 7'h7C);
    assign reg_rdata      = rdata_val;

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    // ---------------- scoreboard ----------------
    logic [W-1:0] exp_q[$];
    logic [15:0]  rd_q[$];
    int checks = 0;
    int errors = 0;
    int rd_cnt = 0;
    int wr_cnt = 0;
    int rply_rise = 0;
    logic rply_prev = 1'b0;
    logic oe_prev = 1'b0;

    function automatic logic [W-1:0] mk_item(input logic [1:0] kind, input logic [12:0] addr,
                                             input logic [15:0] data, input logic [1:0] be);
        return {kind, addr, data, be};
    endfunction

    task automatic chk(input string tag, input logic [35:0] obs, input logic [35:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    always @(negedge clk) begin
        if (reg_read || reg_write) chk("strobe_exclusive", 36'(reg_read & reg_write), 36'd0);
        if (reg_read) begin
            rd_cnt++;
            if (exp_q.size() == 0) chk("unexpected_read", 36'd1, 36'd0);
            else chk("read_item", 36'(mk_item(2'd1, reg_addr, 16'd0, 2'd0)), 36'(exp_q.pop_front()));
        end
        if (reg_write) begin
            wr_cnt++;
            if (exp_q.size() == 0) chk("unexpected_write", 36'd1, 36'd0);
            else chk("write_item", 36'(mk_item(2'd2, reg_addr, reg_wdata, reg_byte_en)), 36'(exp_q.pop_front()));
        end
        if (bus.bus_rdata_oe && !oe_prev) begin
            if (rd_q.size() == 0) chk("unexpected_rdata", 36'd1, 36'd0);
            else chk("bus_rdata", 36'(bus.bus_rdata), 36'(rd_q.pop_front()));
        end
        if (bus.bus_rply && !rply_prev) rply_rise++;
        rply_prev = bus.bus_rply;
        oe_prev   = bus.bus_rdata_oe;
    end

    // ---------------- driver tasks ----------------
    function automatic logic sig(input int sel);
        case (sel)
            0:       return bus.bus_rply;
            1:       return reg_read;
            2:       return reg_write;
            default: return 1'b0;
        endcase
    endfunction

    task automatic drive_at_edge();
        @(posedge clk);
        #1;
    endtask

    task automatic start_cycle(input logic bs7, input logic [12:0] addr);
        drive_at_edge();
        bus.bus_sync = 1'b1;
        bus.bus_bs7  = bs7;
        bus.bus_addr = addr;
    endtask

    task automatic wait_sig(input int sel, input logic val, input string tag);
        int n = 0;
        while (sig(sel) !== val && n < 50) begin
            @(negedge clk);
            n++;
        end
        chk(tag, 36'(sig(sel)), 36'(val));
    endtask

    // Counts negedges from the drive point until the strobe appears.
    task automatic latency(input int sel, input int expn, input string tag);
        int n = 0;
        @(negedge clk);
        while (!sig(sel) && n < 40) begin
            @(negedge clk);
            n++;
        end
        chk(tag, 36'(n), 36'(expn));
    endtask

    task automatic wait_state(input logic [3:0] st, input string tag);
        int n = 0;
        while (dbg_state !== st && n < 50) begin
            @(negedge clk);
            n++;
        end
        chk(tag, 36'(dbg_state), 36'(st));
    endtask

    task automatic end_cycle(input string tag);
        drive_at_edge();
        bus.bus_sync = 1'b0;
        bus.bus_bs7  = 1'b0;
        bus.bus_din  = 1'b0;
        bus.bus_dout = 1'b0;
        bus.bus_wtbt = 1'b0;
        @(negedge clk);
        @(negedge clk);
        chk(tag, 36'(dbg_state), 36'(ST_IDLE));
    endtask

    // Drop DIN or DOUT; RPLY must hold one more sample then fall.
    task automatic drop_data(input string tag);
        drive_at_edge();
        bus.bus_din  = 1'b0;
        bus.bus_dout = 1'b0;
        @(negedge clk);
        chk({tag, "_hold"}, 36'(bus.bus_rply), 36'd1);
        @(negedge clk);
        chk({tag, "_rply_off"}, 36'({bus.bus_rply, bus.bus_rdata_oe}), 36'd0);
    endtask

    // ---------------- directed sequence ----------------
    int rd0, wr0, rr0;
    logic seen_rply;

    initial begin
        reset_n       = 1'b0;
        match_en      = 1'b1;
        rdata_val     = 16'h0000;
        bus.bus_sync  = 1'b0;
        bus.bus_bs7   = 1'b0;
        bus.bus_addr  = 13'd0;
        bus.bus_din   = 1'b0;
        bus.bus_dout  = 1'b0;
        bus.bus_wtbt  = 1'b0;
        bus.bus_wdata = 16'd0;

        // Reset state
        repeat (3) @(negedge clk);
        chk("reset_outputs", 36'({bus.bus_rply, bus.bus_rdata_oe, reg_read, reg_write, bus.bus_rdata}), 36'd0);
        reset_n = 1'b1;
        @(negedge clk);
        chk("reset_regs", 36'({reg_addr, reg_wdata, reg_byte_en}), 36'd0);
        chk("reset_state", 36'(dbg_state), 36'(ST_IDLE));

        // DATI to 0x1F20
        rdata_val = 16'h1234;
        exp_q.push_back(mk_item(2'd1, 13'h1F20, 16'd0, 2'd0));
        rd_q.push_back(16'h1234);
        start_cycle(1'b1, 13'h1F20);
        bus.bus_din = 1'b1;
        latency(1, 2 + MATCH_DLY, "dati_read_latency");
        wait_sig(0, 1'b1, "dati_rply");
        chk("dati_oe", 36'(bus.bus_rdata_oe), 36'd1);
        chk("dati_rdata", 36'(bus.bus_rdata), 36'h1234);
        drop_data("dati");
        chk("dati_back_selected", 36'(dbg_state), 36'(ST_SELECTED));
        end_cycle("dati_idle");

        // DATOB to odd address 0x1F21
        exp_q.push_back(mk_item(2'd2, 13'h1F21, 16'hAB00, 2'b10));
        start_cycle(1'b1, 13'h1F21);
        bus.bus_dout  = 1'b1;
        bus.bus_wtbt  = 1'b1;
        bus.bus_wdata = 16'hAB00;
        latency(2, 2 + MATCH_DLY + DATA_SETUP, "datob_write_latency");
        chk("datob_byte_en", 36'(reg_byte_en), 36'(2'b10));
        wait_sig(0, 1'b1, "datob_rply");
        drop_data("datob");
        end_cycle("datob_idle");

        // DATI to unmatched address
        rd0 = rd_cnt;
        match_en = 1'b0;
        seen_rply = 1'b0;
        start_cycle(1'b1, 13'h1F30);
        bus.bus_din = 1'b1;
        repeat (8) begin
            @(negedge clk);
            seen_rply = seen_rply | bus.bus_rply;
        end
        chk("nxm_no_rply", 36'(seen_rply), 36'd0);
        chk("nxm_no_read", 36'(rd_cnt - rd0), 36'd0);
        chk("nxm_wait_sync", 36'(dbg_state), 36'(ST_WAIT_SYNC));
        end_cycle("nxm_idle");
        match_en = 1'b1;

        // DATIO: read then word write within one SYNC
        rd0 = rd_cnt; wr0 = wr_cnt; rr0 = rply_rise;
        rdata_val = 16'h00FF;
        exp_q.push_back(mk_item(2'd1, 13'h1F02, 16'd0, 2'd0));
        rd_q.push_back(16'h00FF);
        exp_q.push_back(mk_item(2'd2, 13'h1F02, 16'h5555, 2'b11));
        start_cycle(1'b1, 13'h1F02);
        bus.bus_din = 1'b1;
        wait_sig(0, 1'b1, "datio_read_rply");
        drop_data("datio_read");
        drive_at_edge();
        bus.bus_dout  = 1'b1;
        bus.bus_wtbt  = 1'b0;
        bus.bus_wdata = 16'h5555;
        wait_sig(0, 1'b1, "datio_write_rply");
        drop_data("datio_write");
        end_cycle("datio_idle");
        chk("datio_reads", 36'(rd_cnt - rd0), 36'd1);
        chk("datio_writes", 36'(wr_cnt - wr0), 36'd1);
        chk("datio_rply_pulses", 36'(rply_rise - rr0), 36'd2);

        // SYNC drops while the write is still in setup
        wr0 = wr_cnt; rr0 = rply_rise;
        start_cycle(1'b1, 13'h1F04);
        bus.bus_dout  = 1'b1;
        bus.bus_wdata = 16'h7777;
        wait_state(ST_WSETUP, "abort_reach_wsetup");
        drive_at_edge();
        bus.bus_sync = 1'b0;
        @(negedge clk);
        chk("abort_still_wsetup", 36'(dbg_state), 36'(ST_WSETUP));
        @(negedge clk);
        chk("abort_idle", 36'(dbg_state), 36'(ST_IDLE));
        repeat (4) @(negedge clk);
        chk("abort_no_write", 36'(wr_cnt - wr0), 36'd0);
        chk("abort_no_rply", 36'(rply_rise - rr0), 36'd0);
        end_cycle("abort_end");

        // Cycle outside the I/O page
        rd0 = rd_cnt; rr0 = rply_rise;
        start_cycle(1'b0, 13'h1F20);
        bus.bus_din = 1'b1;
        repeat (6) @(negedge clk);
        chk("bs7_wait_sync", 36'(dbg_state), 36'(ST_WAIT_SYNC));
        chk("bs7_no_read", 36'(rd_cnt - rd0), 36'd0);
        chk("bs7_no_rply", 36'(rply_rise - rr0), 36'd0);
        end_cycle("bs7_idle");

        // Reset in the middle of READ_RPLY
        rdata_val = 16'hBEEF;
        exp_q.push_back(mk_item(2'd1, 13'h1F06, 16'd0, 2'd0));
        rd_q.push_back(16'hBEEF);
        start_cycle(1'b1, 13'h1F06);
        bus.bus_din = 1'b1;
        wait_sig(0, 1'b1, "rst_pre_rply");
        #2;
        reset_n = 1'b0;
        #1;
        chk("rst_async_outputs", 36'({bus.bus_rply, bus.bus_rdata_oe, bus.bus_rdata}), 36'd0);
        chk("rst_async_state", 36'(dbg_state), 36'(ST_IDLE));
        bus.bus_sync = 1'b0;
        bus.bus_bs7  = 1'b0;
        bus.bus_din  = 1'b0;
        repeat (2) @(negedge clk);
        reset_n = 1'b1;

        // Normal DATI after reset release
        rdata_val = 16'h0F0F;
        exp_q.push_back(mk_item(2'd1, 13'h1F08, 16'd0, 2'd0));
        rd_q.push_back(16'h0F0F);
        start_cycle(1'b1, 13'h1F08);
        bus.bus_din = 1'b1;
        latency(1, 2 + MATCH_DLY, "post_rst_read_latency");
        wait_sig(0, 1'b1, "post_rst_rply");
        drop_data("post_rst");
        end_cycle("post_rst_idle");

        repeat (2) @(negedge clk);
        chk("exp_q_drained", 36'(exp_q.size()), 36'd0);
        chk("rd_q_drained", 36'(rd_q.size()), 36'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
